// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo : byte FIFO feeding an RS-232 transmitter start/busy handshake
// Revision     : 1.0
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  output logic                  tx_idle
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   C_DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   C_CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_START     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   w_count_nxt;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;
  logic                  r_tx_start;
  logic [7:0]            r_tx_data;
  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  w_wr_ok;
  logic                  w_pop;

  // Write side looks only at registered full, so a same-cycle pop never frees a slot.
  assign w_wr_ok = wr_en && !r_full && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_pop)    w_state_nxt = S_START;
      S_START:                   w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: if (tx_busy)  w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (!tx_busy) w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop = 1'b0;
    if (r_state == S_IDLE && !r_empty && !tx_busy && !flush) begin
      w_pop = 1'b1;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else if (w_wr_ok && !w_pop) begin
      w_count_nxt = r_count + C_CNT_ONE;
    end else if (!w_wr_ok && w_pop) begin
      w_count_nxt = r_count - C_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == C_DEPTH);
      r_empty    <= (w_count_nxt == '0);
      r_tx_start <= w_pop;
      if (flush) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_wr_ok) begin
          r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        end
        if (w_pop) begin
          r_rd_ptr  <= r_rd_ptr + C_PTR_ONE;
          r_tx_data <= r_mem[r_rd_ptr];
        end
        if (wr_en && r_full) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign tx_idle  = r_empty && (r_state == S_IDLE) && !tx_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_fifo : randomized bench with a queue-based transmitter reference
// Revision        : 1.0
// ============================================================================
module tb_uart_tx_fifo;

  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          full;
  logic          empty;
  logic [DL:0]   count;
  logic          overflow;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          tx_idle;

  int total = 0;
  int bad   = 0;

  logic [7:0] rx_q[$];
  int         n_overlap = 0;
  int         n_double  = 0;
  int         rem       = 0;
  bit         stall     = 1'b0;
  bit         prev_start = 1'b0;
  int         tx_min    = 1;
  int         tx_max    = 4;

  uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_idle  (tx_idle)
  );

  always #5 clk = ~clk;

  // Transmitter model: samples start, raises busy one cycle later for a random time.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_busy    <= 1'b0;
      rem        = 0;
      prev_start = 1'b0;
    end else begin
      if (tx_start && tx_busy) n_overlap++;
      if (tx_start && prev_start) n_double++;
      prev_start = tx_start;
      if (tx_start) begin
        rx_q.push_back(tx_data);
        rem = $urandom_range(tx_max, tx_min);
      end
      if (rem > 0) begin
        tx_busy <= 1'b1;
        rem--;
      end else begin
        tx_busy <= stall;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int n_exp, input string tag);
    bit done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      tick();
      if (tx_idle && rx_q.size() == n_exp) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_drain got_bytes=%0d exp_bytes=%0d tx_idle=%0b", tag, rx_q.size(), n_exp, tx_idle);
    end
  endtask

  task automatic test_reset();
    bit saw_start = 1'b0;
    reset_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; stall = 1'b0;
    repeat (3) tick();
    total++; if (empty !== 1'b1)   begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    total++; if (count !== '0)     begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (full !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL reset_flags full=%0b ovf=%0b exp=0,0", full, overflow); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_txdata got=%h exp=00", tx_data); end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_start) saw_start = 1'b1;
    end
    total++; if (saw_start !== 1'b0) begin bad++; $display("FAIL idle_no_start got=%0b exp=0", saw_start); end
    total++; if (tx_idle !== 1'b1)   begin bad++; $display("FAIL idle_txidle got=%0b exp=1", tx_idle); end
  endtask

  task automatic test_single();
    rx_q.delete();
    tx_min = 2; tx_max = 5;
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    total++; if (count !== 5'd1 || empty !== 1'b0 || tx_start !== 1'b0) begin bad++; $display("FAIL single_n count=%0d empty=%0b start=%0b exp=1,0,0", count, empty, tx_start); end
    tick();
    total++; if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin bad++; $display("FAIL single_n1 start=%0b data=%h exp=1,a5", tx_start, tx_data); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL single_count got=%0d exp=0", count); end
    tick();
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_pulse got=%0b exp=0", tx_start); end
    wait_drain(1, "single");
    total++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin bad++; $display("FAIL single_byte got=%h exp=a5", (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
  endtask

  task automatic test_burst();
    int popped;
    rx_q.delete();
    tx_min = 1; tx_max = 6;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    popped = rx_q.size() + (tx_start ? 1 : 0);
    total++; if (count !== 5'(DEPTH - popped)) begin bad++; $display("FAIL burst_count got=%0d exp=%0d", count, DEPTH - popped); end
    total++; if (full !== ((DEPTH - popped) == DEPTH)) begin bad++; $display("FAIL burst_full got=%0b exp=%0b", full, (DEPTH - popped) == DEPTH); end
    wait_drain(DEPTH, "burst");
    for (int i = 0; i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== 8'(i)) begin bad++; $display("FAIL burst_order idx=%0d got=%h exp=%h", i, rx_q[i], 8'(i)); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_b[$];
    rx_q.delete();
    stall = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom_range(0, 8'hED));
      exp_b.push_back(wr_data);
      tick();
    end
    wr_en = 1'b0;
    total++; if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin bad++; $display("FAIL ovf_fill full=%0b count=%0d ovf=%0b exp=1,16,0", full, count, overflow); end
    wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    total++; if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL ovf_set ovf=%0b count=%0d full=%0b exp=1,16,1", overflow, count, full); end
    // Release the transmitter while still writing: the write that meets the first pop is dropped.
    stall = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
    repeat (2) tick();
    wr_en = 1'b0;
    total++; if (count !== 5'd15 || full !== 1'b0) begin bad++; $display("FAIL ovf_pop_write count=%0d full=%0b exp=15,0", count, full); end
    wait_drain(DEPTH, "ovf");
    for (int i = 0; i < rx_q.size() && i < DEPTH; i++) begin
      total++; if (rx_q[i] !== exp_b[i]) begin bad++; $display("FAIL ovf_order idx=%0d got=%h exp=%h", i, rx_q[i], exp_b[i]); end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_flush_clear got=%0b exp=0", overflow); end
  endtask

  task automatic test_flush();
    logic [7:0] first;
    rx_q.delete();
    tx_min = 30; tx_max = 30;
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom);
      if (i == 0) first = wr_data;
      tick();
    end
    wr_en = 1'b0;
    total++; if (count !== 5'd8 || tx_busy !== 1'b1) begin bad++; $display("FAIL flush_pre count=%0d busy=%0b exp=8,1", count, tx_busy); end
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    total++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL flush_state count=%0d empty=%0b full=%0b ovf=%0b exp=0,1,0,0", count, empty, full, overflow); end
    wait_drain(1, "flush");
    repeat (20) tick();
    total++; if (rx_q.size() != 1 || rx_q[0] !== first) begin bad++; $display("FAIL flush_inflight bytes=%0d first=%h exp=1,%h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, first); end
    total++; if (count !== 5'd0 || tx_idle !== 1'b1) begin bad++; $display("FAIL flush_discard count=%0d idle=%0b exp=0,1", count, tx_idle); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[$];
    int n_acc = 0;
    int occ;
    bit do_wr;
    rx_q.delete();
    tx_min = 1; tx_max = 3;
    for (int c = 0; c < 2000 && n_acc < 40; c++) begin
      occ   = n_acc - rx_q.size() - (tx_start ? 1 : 0);
      do_wr = ($urandom_range(0, 3) != 0) && (occ < 14);
      wr_en = do_wr;
      wr_data = 8'($urandom);
      if (do_wr) exp_b.push_back(wr_data);
      tick();
      if (do_wr) n_acc++;
      occ = n_acc - rx_q.size() - (tx_start ? 1 : 0);
      total++; if (count !== 5'(occ)) begin bad++; $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", c, count, occ); end
    end
    wr_en = 1'b0;
    wait_drain(40, "wrap");
    for (int i = 0; i < rx_q.size() && i < exp_b.size(); i++) begin
      total++; if (rx_q[i] !== exp_b[i]) begin bad++; $display("FAIL wrap_order idx=%0d got=%h exp=%h", i, rx_q[i], exp_b[i]); end
    end
    total++; if (n_overlap != 0) begin bad++; $display("FAIL start_while_busy got=%0d exp=0", n_overlap); end
    total++; if (n_double != 0) begin bad++; $display("FAIL start_double got=%0d exp=0", n_double); end
  endtask

  task automatic test_reset_mid();
    rx_q.delete();
    tx_min = 20; tx_max = 20;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom_range(1, 255));
      tick();
    end
    wr_en = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    total++; if (count !== '0 || empty !== 1'b1 || tx_start !== 1'b0 || tx_data !== 8'h00 || overflow !== 1'b0) begin bad++; $display("FAIL reset_mid count=%0d empty=%0b start=%0b data=%h ovf=%0b exp=0,1,0,00,0", count, empty, tx_start, tx_data, overflow); end
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    total++; if (tx_idle !== 1'b1 || rx_q.size() != 1) begin bad++; $display("FAIL reset_mid_idle idle=%0b bytes=%0d exp=1,1", tx_idle, rx_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and launch controller sitting directly upstream of the RS-232 transmitter. Accepts bytes from the capture/command logic at full clock rate into a 2^DEPTH_LOG2-entry FIFO, then feeds them one at a time to the transmitter's start/data/busy handshake so back-to-back bytes go out with no lost characters. Also provides occupancy, a sticky overflow flag, and a flush.

## Interface
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 entries (16 by default); legal range 2..10.

- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe; byte accepted on a rising edge where wr_en=1 and full=0.
- wr_data  in  8  byte to enqueue.
- flush  in  1  synchronous clear of FIFO contents and overflow.
- full  out  1  registered; count == 2^DEPTH_LOG2.
- empty  out  1  registered; count == 0.
- count  out  DEPTH_LOG2+1  registered number of bytes stored, not including a byte already handed to the transmitter.
- overflow  out  1  sticky; set by a write attempted while full=1.
- tx_start  out  1  one-cycle launch pulse to the transmitter.
- tx_data  out  8  byte for the transmitter; valid while tx_start=1.
- tx_busy  in  1  transmitter busy.
- tx_idle  out  1  1 when FIFO empty, FSM in IDLE and tx_busy=0.

## Operation
- Storage: 2^DEPTH_LOG2 x 8 memory; read/write pointers DEPTH_LOG2 bits, wrap modulo depth; count tracks occupancy (no pointer-compare ambiguity).
- Launch FSM, states IDLE, START, WAIT_BUSY, WAIT_DONE:
  - IDLE: if empty=0, tx_busy=0 and flush=0: pop (tx_data <= mem[rd_ptr], rd_ptr++, count--), tx_start <= 1, go START.
  - START: tx_start <= 0, go WAIT_BUSY.
  - WAIT_BUSY: stay until tx_busy=1, then go WAIT_DONE. Needed because the transmitter raises busy one cycle after sampling start.
  - WAIT_DONE: stay until tx_busy=0, then go IDLE.
- The write side uses registered full only. A write while full=1 is dropped and sets overflow, even if a pop occurs in the same cycle.
- Simultaneous write and pop while not full: count unchanged, both pointers advance.
- Flush (any state):
  - Pointers and count go to 0, empty=1, full=0, overflow=0.
  - A write in the same cycle is discarded and does not set overflow.
  - Flush blocks a pop in the same cycle.
  - A byte already launched is not recalled; the FSM continues its handshake.
- tx_data holds the last launched byte until the next pop.

## Timing
- Reset values: tx_start=0, tx_data=0x00, full=0, empty=1, count=0, overflow=0, tx_idle=1, FSM=IDLE, pointers=0.
- Reset asserted mid-byte: all state returns to reset values immediately. The in-flight transmitter byte is the transmitter's concern.
- Write at edge N into an empty FIFO with transmitter idle:
  - empty=0, count=1 after N.
  - Pop at N+1; tx_start=1 between N+1 and N+2.
  - Transmitter samples start at N+2; FSM reaches WAIT_DONE at N+3.
- Between bytes: tx_busy falls at edge M, FSM reaches IDLE at M+1, next tx_start is high M+2..M+3. That is a minimum two-cycle launch gap, negligible versus one bit time.
- tx_start is never high on two consecutive cycles. tx_start is only issued when tx_busy=0.

## Test plan
- Reset then idle: hold reset_n=0, release. Required: empty=1, count=0, tx_idle=1, tx_start never pulses.
- Single byte: write 0xA5 at edge N. Required: tx_start high exactly one cycle at N+1..N+2 with tx_data=0xA5; count 1->0; tx_idle returns to 1 after the transmitter finishes.
- Burst and ordering:
  - Write 0x00..0x0F on 16 consecutive cycles (DEPTH_LOG2=4). Required: full=1 after the 16th write minus any byte already popped.
  - The transmitter model receives 0x00..0x0F in order, with no tx_start while tx_busy=1.
- Overflow: stall tx_busy=1, fill 16 bytes, write 0xEE once more. Required: full=1, count=16, overflow=1, 0xEE never transmitted.
- Flush mid-stream: 8 bytes queued, one byte in flight, assert flush with wr_en=1 on the same cycle. Required:
  - count=0, overflow=0.
  - The in-flight byte completes.
  - No further tx_start.
  - The concurrent write is discarded.
- Wrap-around and simultaneous read/write: stream 40 bytes with writes timed to coincide with pops. Required: pointers wrap, count stays consistent, all 40 bytes are delivered in order.
